rx_hex_writer: RTL
==================

Name: rx_hex_writer

Overview:
- Sits between the UART receiver and the six-digit receive display mux.
- Takes each received byte and converts ASCII hex and a few control characters into active-low 7-segment codes.
- Drives the mux data, digit address and enable strobe.
- Keeps a wrapping write pointer so that successive characters fill HEX5 down to HEX0.

Parameters:
- NUM_DIGITS, 6, number of display positions; pointer range 0..NUM_DIGITS-1.
- CLEAR_CHAR, 8'h0D, received byte that blanks all digits and resets the pointer.
- STROBE_CYCLES, 2, cycles that seg_ena stays high; minimum 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- rx_data  input  8  byte from the UART receiver
- rx_valid  input  1  one-cycle pulse; rx_data is valid in the same cycle
- seg_data  output  8  {dp,g,f,e,d,c,b,a}, active-low; goes to the mux HEXIN
- seg_addr  output  3  digit address; 0..5 select a digit, 7 clears all; goes to the mux addrwin
- seg_ena  output  1  write strobe; goes to the mux ena
- busy  output  1  high while a write sequence is in progress
- overflow  output  1  sticky; set when a byte is dropped, cleared only by rst

Behaviour:
- Reset values: seg_data=8'hFF, seg_addr=3'd7, seg_ena=0, busy=0, overflow=0. Internal state: wr_ptr=0, hold buffer empty, FSM in IDLE.
- All outputs are registered. The mux reacts to both edges of ena, so seg_data and seg_addr must stay stable from SETUP through RELEASE.
- FSM states:
  - IDLE: if a byte is available (hold buffer first, else rx_valid), latch it, decode it, go to SETUP. busy=0 only while in IDLE with no pending byte.
  - SETUP (1 cycle): drive seg_data and seg_addr; seg_ena=0.
  - STROBE (STROBE_CYCLES cycles, down-counter): seg_ena=1.
  - RELEASE (1 cycle): seg_ena=0, data and address held. Then update wr_ptr and go to IDLE.
- Minimum per byte: 3+STROBE_CYCLES cycles from accept to IDLE. The first output change appears 1 cycle after rx_valid.
- Decode table (case-insensitive hex digits):
  - '0'..'9' → C0 F9 A4 B0 99 92 82 F8 80 90
  - 'A'/'a' 88, 'B'/'b' 83, 'C'/'c' C6, 'D'/'d' A1, 'E'/'e' 86, 'F'/'f' 8E
  - space (0x20) → FF (blank)
  - any other byte except CLEAR_CHAR → BF (dash)
- Address mapping: seg_addr = wr_ptr. After RELEASE, wr_ptr increments and wraps from NUM_DIGITS-1 to 0.
- CLEAR_CHAR handling: seg_addr=7, seg_data=FF. The full strobe sequence runs. After RELEASE, wr_ptr=0.
- Buffering: a one-entry hold buffer.
  - rx_valid while the FSM is not in IDLE: store in the hold buffer if it is empty.
  - If the hold buffer is full, drop the byte and set overflow.
  - rx_valid in IDLE while the hold buffer is full: the hold byte is served first, the new byte goes into the hold buffer, and nothing is dropped.
- Reset mid-sequence: outputs return to reset values on the next edge (seg_ena falls). The pointer and hold buffer are cleared. No further strobe is issued.

Decomposition:
- Shared package holds:
  - 7-seg constants SEG_BLANK=8'hFF, SEG_DASH=8'hBF and the 16 hex glyphs
  - ADDR_CLEAR=3'd7
  - FSM state encodings (IDLE, SETUP, STROBE, RELEASE)
- One natural sub-module: ascii_to_seg, purely combinational. Input is a byte; outputs are seg[7:0] and is_clear.

Test Plan:
- Reset, then rx_valid with 0x33 ('3') → seg_addr=0, seg_data=B0; seg_ena high for exactly 2 cycles, starting 2 cycles after rx_valid; wr_ptr becomes 1.
- Send "0123456" at spaced intervals → addresses 0,1,2,3,4,5,0; the seventh write is seg_data=82 at addr 0 (wrap).
- Send 'a', then 'A', then 'z' → data 88, 88, BF; send space → FF.
- Send 0x0D after three digits → seg_addr=7, seg_data=FF strobe; the next byte '1' writes F9 at addr 0.
- Three rx_valid pulses on consecutive cycles ('1','2','3') → '1' and '2' are written, '3' is dropped, overflow=1 and stays 1 until rst.
- Assert rst during STROBE → seg_ena=0 and seg_addr=7 on the next cycle; wr_ptr=0; the following byte writes addr 0.

Source files
------------

// File: rtl/rx_hex_writer_pkg.sv
// Shared 7-segment glyphs, address constants and FSM encoding for the
// receive-side hex display writer.
package rx_hex_writer_pkg;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam logic [7:0] SEG_DASH   = 8'hBF;
    localparam logic [2:0] ADDR_CLEAR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Active-low {dp,g,f,e,d,c,b,a} glyphs for hex values 0..F
    function automatic logic [7:0] hex_glyph(input logic [3:0] value);
        logic [7:0] glyph;
        case (value)
            4'h0: glyph = 8'hC0;
            4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;
            4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;
            4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;
            4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;
            4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;
            4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;
            4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;
            default: glyph = 8'h8E;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/rx_hex_writer_ascii_to_seg.sv
// Combinational ASCII-to-7-segment decoder: hex digits, space, clear
// character, and a dash for anything else.
module ascii_to_seg
    import rx_hex_writer_pkg::*;
#(
    parameter logic [7:0] CLEAR_CHAR = 8'h0D
) (
    input  logic [7:0] ascii,
    output logic [7:0] seg,
    output logic       is_clear
);

    // Letters A-F / a-f have low nibble 1..6, so adding 9 yields 10..15
    always_comb begin
        seg      = SEG_DASH;
        is_clear = 1'b0;
        if (ascii == CLEAR_CHAR) begin
            seg      = SEG_BLANK;
            is_clear = 1'b1;
        end else if (ascii >= 8'h30 && ascii <= 8'h39) begin
            seg = hex_glyph(ascii[3:0]);
        end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                     (ascii >= 8'h61 && ascii <= 8'h66)) begin
            seg = hex_glyph(ascii[3:0] + 4'd9);
        end else if (ascii == 8'h20) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/rx_hex_writer.sv
// Converts received UART bytes into 7-segment writes for the six-digit
// display mux, with a one-entry hold buffer and a wrapping write pointer.
module rx_hex_writer
    import rx_hex_writer_pkg::*;
#(
    parameter int         NUM_DIGITS    = 6,
    parameter logic [7:0] CLEAR_CHAR    = 8'h0D,
    parameter int         STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] seg_data,
    output logic [2:0] seg_addr,
    output logic       seg_ena,
    output logic       busy,
    output logic       overflow
);

    localparam int         CNT_W   = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [2:0] PTR_MAX = 3'(NUM_DIGITS - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [2:0]         wr_ptr, wr_ptr_n;
    logic               hold_valid, hold_valid_n;
    logic [7:0]         hold_data, hold_data_n;
    logic               cur_clear, cur_clear_n;
    logic [7:0]         seg_data_n;
    logic [2:0]         seg_addr_n;
    logic               seg_ena_n, busy_n, overflow_n;
    logic [7:0]         dec_in, dec_seg;
    logic               dec_clear;

    assign dec_in = hold_valid ? hold_data : rx_data;

    ascii_to_seg #(.CLEAR_CHAR(CLEAR_CHAR)) u_decode (
        .ascii    (dec_in),
        .seg      (dec_seg),
        .is_clear (dec_clear)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            wr_ptr     <= 3'd0;
            hold_valid <= 1'b0;
            hold_data  <= 8'h00;
            cur_clear  <= 1'b0;
            seg_data   <= SEG_BLANK;
            seg_addr   <= ADDR_CLEAR;
            seg_ena    <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            wr_ptr     <= wr_ptr_n;
            hold_valid <= hold_valid_n;
            hold_data  <= hold_data_n;
            cur_clear  <= cur_clear_n;
            seg_data   <= seg_data_n;
            seg_addr   <= seg_addr_n;
            seg_ena    <= seg_ena_n;
            busy       <= busy_n;
            overflow   <= overflow_n;
        end
    end

    // Data and address are only changed on accept, so they stay put while
    // the mux sees both edges of the strobe.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        wr_ptr_n     = wr_ptr;
        hold_valid_n = hold_valid;
        hold_data_n  = hold_data;
        cur_clear_n  = cur_clear;
        seg_data_n   = seg_data;
        seg_addr_n   = seg_addr;
        seg_ena_n    = seg_ena;
        overflow_n   = overflow;

        case (state)
            ST_IDLE: begin
                if (hold_valid || rx_valid) begin
                    state_n     = ST_SETUP;
                    seg_data_n  = dec_seg;
                    seg_addr_n  = dec_clear ? ADDR_CLEAR : wr_ptr;
                    cur_clear_n = dec_clear;
                    seg_ena_n   = 1'b0;
                    if (hold_valid) begin
                        hold_valid_n = rx_valid;
                        if (rx_valid) begin
                            hold_data_n = rx_data;
                        end
                    end
                end
            end
            ST_SETUP: begin
                state_n   = ST_STROBE;
                seg_ena_n = 1'b1;
                cnt_n     = CNT_W'(STROBE_CYCLES - 1);
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    state_n   = ST_RELEASE;
                    seg_ena_n = 1'b0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                if (cur_clear || wr_ptr == PTR_MAX) begin
                    wr_ptr_n = 3'd0;
                end else begin
                    wr_ptr_n = wr_ptr + 3'd1;
                end
            end
        endcase

        if (state != ST_IDLE && rx_valid) begin
            if (!hold_valid) begin
                hold_valid_n = 1'b1;
                hold_data_n  = rx_data;
            end else begin
                overflow_n = 1'b1;
            end
        end

        busy_n = !(state_n == ST_IDLE && !hold_valid_n);
    end

endmodule
